// File: rtl/bldc_pwm_commutator_if.sv
// rtl/bldc_pwm_commutator_if.sv - duty/hall/enable inputs and gate/status outputs of the commutator
interface bldc_pwm_commutator_if;
   logic [23:0] duty;
   logic        enable;
   logic [2:0]  hall;
   logic [5:0]  gate;
   logic        pwm_out;
   logic        period_start;
   logic        direction;
   logic        hall_fault;

   modport master (
      output duty, enable, hall,
      input  gate, pwm_out, period_start, direction, hall_fault
   );
   modport slave (
      input  duty, enable, hall,
      output gate, pwm_out, period_start, direction, hall_fault
   );
endinterface

// File: rtl/bldc_pwm_commutator.sv
// rtl/bldc_pwm_commutator.sv - edge-aligned PWM, hall commutation and per-phase dead time
// Optional macro HALL_FILTER_EN: accept a hall code only after HALL_STABLE identical samples.
module bldc_pwm_commutator #(
   parameter int PERIOD      = 2000,
   parameter int DEADTIME    = 10,
   parameter int HALL_STABLE = 16
) (
   input logic                  CLK,
   input logic                  reset_n,
   bldc_pwm_commutator_if.slave bus
);
   localparam int CW = $clog2(PERIOD);
   localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
   localparam logic [15:0]   DEAD_LOAD = 16'(DEADTIME);

   if (HALL_STABLE < 2 || DEADTIME > 65535) begin : g_param_check
      $error("bldc_pwm_commutator: HALL_STABLE must be >= 2 and DEADTIME <= 65535");
   end

   typedef enum logic [1:0] {OFF, DEAD, HIGH, LOW} ph_state_t;

   logic [CW-1:0] cnt;
   logic [23:0]   shadow;
   logic [23:0]   mag_abs;
   logic [23:0]   mag;
   logic          pwm_raw;
   logic [2:0]    hall_s1;
   logic [2:0]    hall_s2;
   logic [2:0]    hall_acc;
   logic          code_ok;
   logic [1:0]    hi_ph;
   logic [1:0]    lo_ph;
   logic [1:0]    chop_ph;
   logic [1:0]    hold_ph;
   ph_state_t     ph_state [3];
   ph_state_t     ph_req   [3];
   logic [15:0]   ph_timer [3];

   // Most negative duty has no positive twin in 24 bits, so it saturates first.
   always_comb begin
      if (!shadow[23])                mag_abs = shadow;
      else if (shadow == 24'h800000)  mag_abs = 24'h7FFFFF;
      else                            mag_abs = -shadow;
      mag     = (mag_abs > 24'(PERIOD)) ? 24'(PERIOD) : mag_abs;
      pwm_raw = ({{(24-CW){1'b0}}, cnt} < mag);
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         cnt              <= '0;
         shadow           <= '0;
         bus.direction    <= 1'b0;
         bus.pwm_out      <= 1'b0;
         bus.period_start <= 1'b0;
         bus.hall_fault   <= 1'b0;
         hall_s1          <= '0;
         hall_s2          <= '0;
      end else begin
         cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         if (cnt == CNT_LAST) begin
            shadow        <= bus.duty;
            bus.direction <= bus.duty[23];
         end
         bus.period_start <= (cnt == CNT_LAST);
         bus.pwm_out      <= pwm_raw;
         bus.hall_fault   <= !code_ok;
         hall_s1          <= bus.hall;
         hall_s2          <= hall_s1;
      end
   end

`ifdef HALL_FILTER_EN
   localparam int FW = $clog2(HALL_STABLE + 1);
   logic [2:0]    hall_cand;
   logic [FW-1:0] stable_cnt;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         hall_cand  <= '0;
         stable_cnt <= '0;
         hall_acc   <= '0;
      end else if (hall_s2 != hall_cand) begin
         hall_cand  <= hall_s2;
         stable_cnt <= FW'(1);
      end else begin
         if (stable_cnt != FW'(HALL_STABLE)) stable_cnt <= stable_cnt + FW'(1);
         if (stable_cnt == FW'(HALL_STABLE - 1)) hall_acc <= hall_cand;
      end
   end
`else
   assign hall_acc = hall_s2;
`endif

   // Phase index 0/1/2 = A/B/C; reverse simply swaps chopped and held phase.
   always_comb begin
      code_ok = 1'b1;
      hi_ph   = 2'd0;
      lo_ph   = 2'd1;
      case (hall_acc)
         3'b101:  begin hi_ph = 2'd0; lo_ph = 2'd1; end
         3'b100:  begin hi_ph = 2'd0; lo_ph = 2'd2; end
         3'b110:  begin hi_ph = 2'd1; lo_ph = 2'd2; end
         3'b010:  begin hi_ph = 2'd1; lo_ph = 2'd0; end
         3'b011:  begin hi_ph = 2'd2; lo_ph = 2'd0; end
         3'b001:  begin hi_ph = 2'd2; lo_ph = 2'd1; end
         default: code_ok = 1'b0;
      endcase
      chop_ph = bus.direction ? lo_ph : hi_ph;
      hold_ph = bus.direction ? hi_ph : lo_ph;
      for (int p = 0; p < 3; p++) begin
         ph_req[p] = OFF;
         if (code_ok && 2'(p) == chop_ph)      ph_req[p] = pwm_raw ? HIGH : OFF;
         else if (code_ok && 2'(p) == hold_ph) ph_req[p] = LOW;
      end
   end

   // DEAD always lasts max(DEADTIME,1) cycles; the target is whatever is requested at exit.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < 3; p++) begin
            ph_state[p] <= OFF;
            ph_timer[p] <= '0;
         end
      end else begin
         for (int p = 0; p < 3; p++) begin
            if (!bus.enable) begin
               ph_state[p] <= OFF;
            end else begin
               case (ph_state[p])
                  OFF: begin
                     if (ph_req[p] != OFF) begin
                        ph_state[p] <= DEAD;
                        ph_timer[p] <= DEAD_LOAD;
                     end
                  end
                  DEAD: begin
                     if (ph_timer[p] <= 16'd1) ph_state[p] <= ph_req[p];
                     else                      ph_timer[p] <= ph_timer[p] - 16'd1;
                  end
                  default: begin
                     if (ph_req[p] == OFF) begin
                        ph_state[p] <= OFF;
                     end else if (ph_req[p] != ph_state[p]) begin
                        ph_state[p] <= DEAD;
                        ph_timer[p] <= DEAD_LOAD;
                     end
                  end
               endcase
            end
         end
      end
   end

   assign bus.gate = {ph_state[0] == HIGH, ph_state[0] == LOW,
                      ph_state[1] == HIGH, ph_state[1] == LOW,
                      ph_state[2] == HIGH, ph_state[2] == LOW};
endmodule

// File: doc/bldc_pwm_commutator.md
Name: bldc_pwm_commutator

Overview:
- Downstream stage of the motor PID controller.
- Consumes the signed 24-bit duty word and converts it into a centre-free, edge-aligned PWM.
- Selects the driven phase pair from the 3-bit hall sensor, applies direction from the duty sign, and inserts dead time per half-bridge.
- Drives the six gate signals of the three-phase bridge.

Parameters:
- PERIOD, 2000, PWM period in CLK cycles; counter runs 0..PERIOD-1.
- DEADTIME, 10, CLK cycles a half-bridge stays fully off before any switch turns on.
- HALL_STABLE, 16, cycles a hall code must persist before acceptance (HALL_FILTER_EN only).

Ports:
- CLK  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- duty  input  24  signed duty from PID; magnitude = on-time in cycles, sign = direction.
- enable  input  1  0 forces all gates off.
- hall  input  3  raw hall sensors {HA_s,HB_s,HC_s}, asynchronous.
- gate  output  6  bridge gates, index 5..0 = HA,LA,HB,LB,HC,LC, active-high.
- pwm_out  output  1  registered raw PWM (counter < magnitude).
- period_start  output  1  one-cycle pulse when counter==0.
- direction  output  1  latched sign of duty: 0 forward, 1 reverse.
- hall_fault  output  1  high while accepted hall code is 000 or 111.

Behaviour:
- Reset (reset_n low, async): gate=0, pwm_out=0, period_start=0, direction=0, hall_fault=0, counter=0, duty shadow=0, all phase FSMs OFF, hall sync flops=0.
- Counter: increments each cycle, wraps PERIOD-1 -> 0. period_start registered, high in the cycle counter==0.
- Duty shadow: duty sampled only when counter==PERIOD-1; the new value governs the period starting at the next counter==0. Mid-period duty changes are ignored.
- Magnitude: |duty|. -8388608 saturates to 8388607. Magnitude is then clipped to PERIOD.
- direction is the shadow sign bit. Zero duty gives direction 0.
- pwm_raw = (counter < mag). mag=0 gives constant 0. mag>=PERIOD gives constant 1. pwm_out = pwm_raw registered, 1 cycle latency.
- Hall path: 2-flop synchroniser. Accepted code = synchronised code, or filtered code (see Optional Feature).
- Commutation, forward (high-side phase PWM-chopped / low-side phase held on):
  - 101: A/B
  - 100: A/C
  - 110: B/C
  - 010: B/A
  - 011: C/A
  - 001: C/B
  - Reverse swaps the roles in each entry.
  - Unlisted phase: OFF.
  - 000/111: all phases OFF, hall_fault=1.
- Per-phase request:
  - HIGH if high-side phase and pwm_raw=1.
  - OFF if high-side phase and pwm_raw=0.
  - LOW if low-side phase.
  - OFF otherwise.
- Per-phase FSM, states OFF, DEAD, HIGH, LOW:
  - OFF -> DEAD on request HIGH/LOW; load timer=DEADTIME.
  - DEAD: timer decrements each cycle. At 0, enter the current request; if the request is OFF, enter OFF. A request change during DEAD updates the target but does not restart the timer.
  - HIGH/LOW: request OFF -> OFF next cycle. Request for the opposite state -> DEAD with timer reload.
  - Gate outputs: HIGH drives Hx=1, LOW drives Lx=1, all other states drive both 0.
- Invariant: Hx and Lx never both 1. After any on-switch turns off, either switch of that phase stays off for at least DEADTIME cycles.
- enable=0: all FSMs forced OFF and gate=0 on the next edge. Counter and shadow keep running. Re-enable re-enters through DEAD.
- Hall change mid-period: new requests apply on the next cycle after acceptance, through the FSM rules. Duty-sign change takes effect only at the period boundary.
- DEADTIME=0: DEAD lasts 1 cycle (minimum).

Optional Feature:
- Macro HALL_FILTER_EN.
- Defined: a synchronised hall code is accepted only after HALL_STABLE consecutive identical samples. Any glitch restarts the count, and the accepted code holds its previous value meanwhile.
- Undefined: the synchronised code is accepted directly, 2-cycle latency.

Test Plan:
- Reset release, duty=500, PERIOD=2000, hall=101, enable=1 -> from the second period, pwm_out high for 500 cycles/period. HA follows pwm_out delayed by DEADTIME=10 on the rising edge only. LB=1 steady. HB, LA, HC, LC=0.
- duty=-500, hall=101 -> after the next period boundary direction=1; HB chops and LA steady. The A-phase transition passes through 10 cycles of HA=LA=0.
- duty=2500 then -8388608 -> pwm_out constant 1, no assertion failure. Both values clip to 2000.
- hall 101->000 mid-period -> hall_fault=1 and gate=0 within 3 cycles. Return to 100 -> gates resume via DEAD (HA on after ≥10 cycles, LC on after 10).
- enable toggled 0 for 50 cycles while HA=1 -> gate=0 next edge; on re-enable, HA returns ≥10 cycles later. reset_n pulsed low mid-period -> all outputs 0 asynchronously.
- With HALL_FILTER_EN: hall glitch of 5 cycles -> no gate change. Stable change held 16 cycles -> accepted. Check Hx&Lx==0 every cycle in all tests.
